// File: rtl/lcd_pkg.sv
// Shared types and defaults for the LCD power/enable sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_OFF          = 3'd0,
        ST_PWR_WAIT     = 3'd1,
        ST_SYNC_WAIT    = 3'd2,
        ST_RAMP_UP      = 3'd3,
        ST_ON           = 3'd4,
        ST_RAMP_DOWN    = 3'd5,
        ST_SYNC_OFF     = 3'd6,
        ST_PWR_OFF_WAIT = 3'd7
    } state_e;

    // Defaults for a 25 MHz pixel clock.
    localparam int unsigned PWR_CYC_DEF     = 250000;   // 10 ms rail settle
    localparam int unsigned WARM_FRAMES_DEF = 2;
    localparam int unsigned RAMP_DIV_DEF    = 25000;    // 1 ms per backlight step
    localparam int unsigned WD_CYC_DEF      = 2500000;  // 100 ms sync watchdog

    // Rail / driver / DISP pattern for a state, returned as {pwr, drv, disp}.
    function automatic logic [2:0] rail_outs(input state_e s);
        logic [2:0] r;
        case (s)
            ST_OFF:                            r = 3'b000;
            ST_PWR_WAIT, ST_PWR_OFF_WAIT:      r = 3'b100;
            ST_SYNC_WAIT, ST_SYNC_OFF:         r = 3'b110;
            ST_RAMP_UP, ST_ON, ST_RAMP_DOWN:   r = 3'b111;
            default:                           r = 3'b000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lcd_power_seq_if.sv
// Control/status bundle between the panel power sequencer and its host.
// Latency: n/a (wires only).
// Backpressure: none; all inputs are levels, all outputs are registered levels.
interface lcd_power_seq_if;
    logic       power_req;   // 1 = panel on requested
    logic [7:0] bl_level;    // target backlight duty
    logic       vsync;       // driver vsync, active-low
    logic       lcd_pwr_en;  // panel rail enable
    logic       drv_en;      // timing-driver enable
    logic       lcd_disp;    // panel DISP pin
    logic       bl_pwm;      // backlight PWM
    logic       panel_on;    // high only in ON
    logic       busy;        // high outside OFF and ON
    logic       fault;       // sticky sync watchdog flag
    logic [2:0] state;       // current state encoding

    modport master (
        output power_req, bl_level, vsync,
        input  lcd_pwr_en, drv_en, lcd_disp, bl_pwm, panel_on, busy, fault, state
    );

    modport slave (
        input  power_req, bl_level, vsync,
        output lcd_pwr_en, drv_en, lcd_disp, bl_pwm, panel_on, busy, fault, state
    );
endinterface

// File: rtl/lcd_bl_pwm.sv
// Backlight PWM: free-running 8-bit counter compared against duty.
// Latency: pwm follows a duty change after 1 cycle (registered compare).
// Backpressure: none. Ports: clk, rst_n, duty[7:0] in; pwm out.
module lcd_bl_pwm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] duty,
    output logic       pwm
);
    logic [7:0] pwm_cnt;

    // duty 0 never fires; duty 255 is high 255 of every 256 cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= 8'd0;
            pwm     <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            pwm     <= (pwm_cnt < duty);
        end
    end
endmodule

// File: rtl/lcd_power_seq.sv
// LCD panel power sequencer: orders rail, driver enable, DISP and backlight ramp.
// Latency: outputs registered, decoded from next-state so they change with the state register.
// Backpressure: none; power_req/bl_level are levels, vsync is sampled every cycle.
// Ports: clk, rst_n (async active-low); bus (slave) carries requests and all status outputs.
module lcd_power_seq
    import lcd_pkg::*;
#(
    parameter int unsigned PWR_CYC     = PWR_CYC_DEF,
    parameter int unsigned WARM_FRAMES = WARM_FRAMES_DEF,
    parameter int unsigned RAMP_DIV    = RAMP_DIV_DEF,
    parameter int unsigned WD_CYC      = WD_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    lcd_power_seq_if.slave   bus
);
    state_e      state_q, state_d;
    logic [31:0] dly_cnt, rdiv_cnt, frm_cnt;
    logic [7:0]  bl_cur, bl_nxt, bl_tgt;
    logic        vsync_q, vs_fall, ramp_step, entry, fault_q, fault_set;
    logic        pwr_q, drv_q, disp_q, on_q, busy_q;
    logic        dly_end, frames_done;

    assign vs_fall     = vsync_q & ~bus.vsync;
    assign ramp_step   = (rdiv_cnt == RAMP_DIV - 1);
    assign dly_end     = (dly_cnt == PWR_CYC - 1);
    assign frames_done = (frm_cnt >= WARM_FRAMES);
    assign entry       = (state_d != state_q);

    // One step toward the target per divider period; saturates at the target.
    always_comb begin
        bl_tgt = (state_q == ST_RAMP_UP || state_q == ST_ON) ? bus.bl_level : 8'd0;
        bl_nxt = bl_cur;
        if (ramp_step) begin
            if (bl_cur < bl_tgt)      bl_nxt = bl_cur + 8'd1;
            else if (bl_cur > bl_tgt) bl_nxt = bl_cur - 8'd1;
        end
    end

    // Ramp exits look at bl_nxt so the state changes on the same edge that
    // bl_cur lands on its target.
    always_comb begin
        state_d   = state_q;
        fault_set = 1'b0;
        case (state_q)
            ST_OFF:          if (bus.power_req && !fault_q) state_d = ST_PWR_WAIT;
            ST_PWR_WAIT:     if (!bus.power_req)  state_d = ST_PWR_OFF_WAIT;
                             else if (dly_end)    state_d = ST_SYNC_WAIT;
            ST_SYNC_WAIT:    if (!bus.power_req)  state_d = ST_PWR_OFF_WAIT;
                             else if (frames_done) state_d = ST_RAMP_UP;
                             else if (dly_cnt == WD_CYC - 1) begin
                                 fault_set = 1'b1;
                                 state_d   = ST_PWR_OFF_WAIT;
                             end
            ST_RAMP_UP:      if (!bus.power_req)  state_d = ST_RAMP_DOWN;
                             else if (bl_nxt == bus.bl_level) state_d = ST_ON;
            ST_ON:           if (!bus.power_req)  state_d = ST_RAMP_DOWN;
            ST_RAMP_DOWN:    if (bus.power_req)   state_d = ST_RAMP_UP;
                             else if (bl_nxt == 8'd0) state_d = ST_SYNC_OFF;
            ST_SYNC_OFF:     if (frames_done)     state_d = ST_PWR_OFF_WAIT;
            ST_PWR_OFF_WAIT: if (dly_end)         state_d = ST_OFF;
            default:         state_d = ST_OFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_OFF;
            vsync_q  <= 1'b0;
            dly_cnt  <= 32'd0;
            frm_cnt  <= 32'd0;
            rdiv_cnt <= 32'd0;
            bl_cur   <= 8'd0;
            fault_q  <= 1'b0;
            pwr_q    <= 1'b0;
            drv_q    <= 1'b0;
            disp_q   <= 1'b0;
            on_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vsync_q <= bus.vsync;

            // Shared by the rail delays and the sync watchdog.
            if (entry)
                dly_cnt <= 32'd0;
            else if (state_q inside {ST_PWR_WAIT, ST_SYNC_WAIT, ST_PWR_OFF_WAIT})
                dly_cnt <= dly_cnt + 32'd1;
            else
                dly_cnt <= 32'd0;

            if (entry)
                frm_cnt <= 32'd0;
            else if (vs_fall && (state_q inside {ST_SYNC_WAIT, ST_SYNC_OFF}))
                frm_cnt <= frm_cnt + 32'd1;

            // Divider free-runs in ON so level changes track at ramp rate.
            if (state_d inside {ST_RAMP_UP, ST_RAMP_DOWN} && entry)
                rdiv_cnt <= 32'd0;
            else if (state_d inside {ST_RAMP_UP, ST_ON, ST_RAMP_DOWN})
                rdiv_cnt <= ramp_step ? 32'd0 : rdiv_cnt + 32'd1;
            else
                rdiv_cnt <= 32'd0;

            bl_cur <= (state_d inside {ST_RAMP_UP, ST_ON, ST_RAMP_DOWN}) ? bl_nxt : 8'd0;

            if (fault_set)
                fault_q <= 1'b1;
            else if (state_q == ST_OFF && !bus.power_req)
                fault_q <= 1'b0;

            {pwr_q, drv_q, disp_q} <= rail_outs(state_d);
            on_q   <= (state_d == ST_ON);
            busy_q <= !(state_d == ST_OFF || state_d == ST_ON);
        end
    end

    lcd_bl_pwm u_pwm (
        .clk   (clk),
        .rst_n (rst_n),
        .duty  (bl_cur),
        .pwm   (bus.bl_pwm)
    );

    assign bus.lcd_pwr_en = pwr_q;
    assign bus.drv_en     = drv_q;
    assign bus.lcd_disp   = disp_q;
    assign bus.panel_on   = on_q;
    assign bus.busy       = busy_q;
    assign bus.fault      = fault_q;
    assign bus.state      = state_q;
endmodule
